// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - exhaustive input sweep driver with truth-table, MISR and ones-count capture
module tt_sweep_capture #(
    parameter int               N_IN    = 8,
    parameter int               DUT_LAT = 0,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x,
    input  logic              y,
    input  logic [SIG_W-1:0]  exp_sig,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     ones_count,
    output logic              match,
    input  logic [N_IN-1:0]   tt_idx,
    output logic              tt_bit
);
    localparam int DEPTH = 2 ** N_IN;
    localparam int DW    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);
    localparam logic [N_IN-1:0] X_MAX      = '1;
    localparam logic [N_IN-1:0] X_ONE      = {{(N_IN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [N_IN-1:0]     r_x;
    logic [DW-1:0]       r_drain;
    logic [SIG_W-1:0]    r_sig;
    logic [SIG_W-1:0]    r_exp;
    logic [N_IN:0]       r_ones;
    logic [DEPTH-1:0]    r_tt;
    logic                r_done;
    logic                r_match;
    // Stage 0 runs alongside r_x; stage DUT_LAT names the index whose response is on y now.
    logic                r_pv [0:DUT_LAT];
    logic [N_IN-1:0]     r_pi [0:DUT_LAT];

    logic                w_cap_v;
    logic [N_IN-1:0]     w_cap_i;
    logic [SIG_W-1:0]    w_sig_next;
    logic [SIG_W-1:0]    w_sig_fin;

    always_comb begin
        w_cap_v    = r_pv[DUT_LAT];
        w_cap_i    = r_pi[DUT_LAT];
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                   ^ {{(SIG_W-1){1'b0}}, y};
        w_sig_fin  = w_cap_v ? w_sig_next : r_sig;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_drain <= '0;
            r_sig   <= SEED;
            r_exp   <= '0;
            r_ones  <= '0;
            r_tt    <= '0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            for (int i = 0; i <= DUT_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pi[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;

            if (w_cap_v) begin
                r_tt[w_cap_i] <= y;
                r_ones        <= r_ones + {{N_IN{1'b0}}, y};
                r_sig         <= w_sig_next;
            end

            for (int i = DUT_LAT; i >= 1; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pi[i] <= r_pi[i-1];
            end
            r_pv[0] <= 1'b0;
            r_pi[0] <= '0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SWEEP;
                        r_x     <= '0;
                        r_sig   <= SEED;
                        r_ones  <= '0;
                        r_tt    <= '0;
                        r_exp   <= exp_sig;
                        r_match <= 1'b0;
                        r_pv[0] <= 1'b1;
                        r_pi[0] <= '0;
                    end
                end
                S_SWEEP: begin
                    if (r_x == X_MAX) begin
                        r_x <= '0;
                        if (DUT_LAT > 0) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_match <= (w_sig_fin == r_exp);
                        end
                    end else begin
                        r_x     <= r_x + X_ONE;
                        r_pv[0] <= 1'b1;
                        r_pi[0] <= r_x + X_ONE;
                    end
                end
                S_DRAIN: begin
                    // The final in-flight sample lands on the same edge that enters DONE.
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_match <= (w_sig_fin == r_exp);
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x          = r_x;
    assign busy       = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done       = r_done;
    assign signature  = r_sig;
    assign ones_count = r_ones;
    assign match      = r_match;
    assign tt_bit     = r_tt[tt_idx];
endmodule
